// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and the sub-word store merge helper
// for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [0:0] {IDLE, MERGE} lsu_state_t;

  // Replace the addressed byte or halfword of a memory word with store data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                              input logic [1:0]  byte_off,
                                              input logic [2:0]  funct3,
                                              input logic [31:0] data);
    logic [31:0] merged;
    merged = word;
    if (funct3 == F3_B) begin
      merged[{byte_off, 3'b000} +: 8] = data[7:0];
    end else if (funct3 == F3_H) begin
      merged[{byte_off[1], 4'b0000} +: 16] = data[15:0];
    end
    return merged;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane selection and sign/zero extension; also flags funct3
// values that are not legal RV32I loads.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        illegal
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    unique case (byte_off)
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
    lane_half = byte_off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (funct3)
      F3_B:    data = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    data = {{16{lane_half[15]}}, lane_half};
      F3_W:    data = word;
      F3_BU:   data = {24'h0, lane_byte};
      F3_HU:   data = {16'h0, lane_half};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store front end for a word-addressed DataMem.
// Sub-word stores are a stalled read-modify-write over two cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic        stall,
  output logic        fault,
  output logic [31:0] faultAddr,
  output logic [31:0] dmAddress,
  output logic [31:0] dmWdata,
  output logic        dmWrite,
  input  logic [31:0] dmRdata
);

  lsu_state_t  state;
  logic [31:0] merge_word;
  logic [29:0] merge_idx;

  logic [31:0] aligned_data;
  logic        load_f3_bad;
  logic        store_f3_bad;
  logic        misaligned;
  logic        out_of_range;
  logic        req_bad;
  logic        idle_req;
  logic        fault_now;
  logic        sub_store;

  load_align u_load_align (
    .word     (dmRdata),
    .byte_off (addr[1:0]),
    .funct3   (funct3),
    .data     (aligned_data),
    .illegal  (load_f3_bad)
  );

  always_comb begin
    store_f3_bad = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    misaligned   = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                   (funct3 == F3_W && addr[1:0] != 2'b00);
    out_of_range = {2'b00, addr[31:2]} >= MEM_WORDS;
    req_bad      = (memRead && memWrite) || (memRead && load_f3_bad) ||
                   (memWrite && store_f3_bad) || misaligned || out_of_range;
    idle_req     = !rst && state == IDLE && (memRead || memWrite);
    fault_now    = idle_req && req_bad;
    sub_store    = idle_req && !req_bad && memWrite && funct3 != F3_W;
  end

  // In MERGE the live request inputs are ignored; only the registers drive DataMem.
  always_comb begin
    loadData  = '0;
    stall     = 1'b0;
    fault     = fault_now;
    dmAddress = {2'b00, addr[31:2]};
    dmWdata   = storeData;
    dmWrite   = 1'b0;
    if (state == MERGE) begin
      dmAddress = {2'b00, merge_idx};
      dmWdata   = merge_word;
      dmWrite   = !rst;
    end else if (idle_req && !req_bad) begin
      if (memRead) begin
        loadData = aligned_data;
      end else if (sub_store) begin
        stall = 1'b1;
      end else begin
        dmWrite = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      faultAddr  <= '0;
      merge_word <= '0;
      merge_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fault_now) begin
            faultAddr <= addr;
          end
          if (sub_store) begin
            merge_word <= merge_lanes(dmRdata, addr[1:0], funct3, storeData);
            merge_idx  <= addr[31:2];
            state      <= MERGE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end between the single-cycle core's execute stage and the word-addressed `DataMem`. Translates RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses: loads extract and extend in the same cycle, and sub-word stores run as a two-cycle registered read-modify-write with a core stall. Misaligned, out-of-range or illegal accesses raise a fault, suppress the memory write and capture the faulting address.

## Interface
- `MEM_WORDS`, 1024: `DataMem` depth in 32-bit words; valid byte addresses are 0 .. 4*MEM_WORDS-1.
- `clk`  in  1  single clock, all state on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `memRead`  in  1  core load request.
- `memWrite`  in  1  core store request.
- `funct3`  in  3  RV32I load/store width/sign field.
- `addr`  in  32  byte address.
- `storeData`  in  32  store source (rs2).
- `loadData`  out  32  extended load result to writeback.
- `stall`  out  1  core must hold PC and all request inputs.
- `fault`  out  1  access rejected this cycle.
- `faultAddr`  out  32  byte address of most recent fault.
- `dmAddress`  out  32  word index to `DataMem`, equal to {2'b00, addr[31:2]}.
- `dmWdata`  out  32  write word to `DataMem`.
- `dmWrite`  out  1  `DataMem` write enable.
- `dmRdata`  in  32  `DataMem` combinational read word.

## Operation
- Legal funct3 values: loads 0 (LB), 1 (LH), 2 (LW), 4 (LBU), 5 (LHU); stores 0 (SB), 1 (SH), 2 (SW).
- Fault conditions: any other funct3; halfword with addr[0]=1; word with addr[1:0]≠0; addr[31:2] ≥ MEM_WORDS; memRead and memWrite both high. A faulting request drives `fault`=1, `dmWrite`=0, `loadData`=0, `stall`=0, and loads `faultAddr`<=addr at the clock edge.
- Loads (IDLE only): the byte lane is selected by addr[1:0] and the halfword by addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word. The result is combinational with no stall.
- SW (IDLE): `dmWdata`=storeData, `dmWrite`=1 in the same cycle, no stall.
- SB/SH are a two-state FSM (IDLE, MERGE):
  - IDLE with a legal SB/SH: `stall`=1 and `dmWrite`=0. On the clock edge, register `mergeWord` = dmRdata with the addressed lane(s) replaced by storeData[7:0] or storeData[15:0]. Also register `mergeIdx` = addr[31:2], then go to MERGE.
  - MERGE: `dmAddress`={2'b00, mergeIdx} and `dmWdata`=mergeWord, taken from the registers and not the live inputs. `dmWrite`=1, `stall`=0, `fault`=0, then go to IDLE unconditionally.
- When memRead=memWrite=0 in IDLE: `dmWrite`=0, `loadData`=0, `stall`=0, `fault`=0.
- `faultAddr` holds its value until the next fault.

## Timing
- Reset values: state=IDLE, `faultAddr`=0, `mergeWord`=0, `mergeIdx`=0. While `rst`=1, `dmWrite`=0, `stall`=0 and `fault`=0 regardless of state.
- Latency:
  - Loads, SW and faults take 1 cycle.
  - SB/SH take 2 cycles: stall in cycle 0 and the write in cycle 1. The core retires the store at the end of cycle 1.
- The core's request inputs must be stable during the stalled cycle. In MERGE the live inputs are ignored, so the next instruction's request is not serviced until the following IDLE cycle.
- `rst` asserted in MERGE: no write occurs and the state is IDLE next cycle, so a partial store is dropped.
- The merge uses `dmRdata` sampled in the IDLE cycle. No other `DataMem` writer exists, so the read-modify-write is atomic.

## Structure
- `lsu_pkg`: funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the `lsu_state_t` enum {IDLE, MERGE}.
- Sub-module `load_align` (combinational): inputs are the word, addr[1:0] and funct3; outputs are the extended `loadData` and an illegal-funct3 flag. It is instantiated once.
- The FSM, merge registers, fault detection and `DataMem`-side muxing stay in `load_store_unit`.

## Test plan
- Pre-load word 2 = 32'h8899AABB. LB at addr 0x0B gives `loadData`=32'hFFFFFF88. LBU at 0x0B gives 32'h00000088. LH at 0x08 gives 32'hFFFFAABB. LHU at 0x0A gives 32'h00008899. All with no stall.
- Word 2 = 32'h8899AABB, SB storeData=32'h12345677 at 0x09:
  - Cycle 0: `stall`=1 and `dmWrite`=0.
  - Cycle 1: `dmWrite`=1, `dmAddress`=2, `dmWdata`=32'h889977BB.
  - A following LW at 0x08 returns 32'h889977BB.
- SH storeData=32'h0000CAFE at 0x0E over word 3 = 0: the write in cycle 1 is 32'hCAFE0000. SW 32'hDEADBEEF at 0x10 writes in 1 cycle with `stall`=0.
- Faults:
  - LW at 0x06 gives `fault`=1, `dmWrite`=0, `loadData`=0, then `faultAddr`=0x06.
  - SH at 0x0F gives `fault`=1 with no write.
  - SW at 0x1000 (word 1024) gives `fault`=1.
  - funct3=3 gives `fault`=1.
- `rst` asserted in the MERGE cycle of an SB: `dmWrite`=0, the memory word is unchanged, the state is IDLE next cycle, and `faultAddr` and the merge registers are 0.
